// File: rtl/uart_rx.sv
// Serial receiver: synchronises the line, finds the start edge, samples each bit
// at its centre and presents the word in parallel with valid / frame-error strobes.
module uart_rx #(
    parameter int WIDTH         = 8,
    parameter int DIVISOR       = 100,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int BCW = $clog2(DIVISOR);
    localparam int SCW = $clog2(WIDTH) + 1;
    localparam logic [BCW-1:0] HALF_M1 = BCW'(DIVISOR/2 - 1);
    localparam logic [BCW-1:0] FULL_M1 = BCW'(DIVISOR - 1);
    localparam logic [BCW-1:0] BC_ZERO = BCW'(0);
    localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
    localparam logic [SCW-1:0] LAST_S  = SCW'(WIDTH - 1);
    localparam logic [SCW-1:0] SC_ZERO = SCW'(0);
    localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             rx_m_q, rx_s_q, rx_d_q;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]   s_cnt_q, s_cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] sh_shift_s;

    // Shift register insertion point depends on the bit order on the wire
    always_comb begin
        sh_shift_s = sh_q;
        if (LITTLE_ENDIAN != 0) begin
            sh_shift_s = {rx_s_q, sh_q[WIDTH-1:1]};
        end else begin
            sh_shift_s = {sh_q[WIDTH-2:0], rx_s_q};
        end
    end

    // Next-state and strobe decode; every sampling decision looks at rx_s only
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        s_cnt_d   = s_cnt_q;
        sh_d      = sh_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = BC_ZERO;
                s_cnt_d   = SC_ZERO;
                if (rx_d_q && !rx_s_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d = BC_ZERO;
                    s_cnt_d   = SC_ZERO;
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = BC_ZERO;
                    sh_d      = sh_shift_s;
                    s_cnt_d   = s_cnt_q + SC_ONE;
                    if (s_cnt_q == LAST_S) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = BC_ZERO;
                    state_d   = ST_IDLE;
                    if (rx_s_q) begin
                        data_d = sh_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = BC_ZERO;
                s_cnt_d   = SC_ZERO;
            end
        endcase
    end

    // Synchroniser, edge-detect flop and all FSM / output registers
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= BC_ZERO;
            s_cnt_q   <= SC_ZERO;
            sh_q      <= {WIDTH{1'b0}};
            data_q    <= {WIDTH{1'b0}};
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_m_q    <= i_rx;
            rx_s_q    <= rx_m_q;
            rx_d_q    <= rx_s_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            s_cnt_q   <= s_cnt_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
        end
    end

    assign o_data      = data_q;
    assign o_dv        = dv_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one MSB-first and one LSB-first receiver share a driven line;
// a per-receiver scoreboard checks every strobe against frames queued at drive time.
module tb_uart_rx;

    localparam int D = 100;
    localparam int W = 8;

    typedef struct {
        logic         is_err;
        logic [W-1:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         rx;
    logic [W-1:0] be_data, le_data;
    logic         be_dv, be_err, be_busy;
    logic         le_dv, le_err, le_busy;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int start_cyc = 0;
    int dv_cyc_be = -1;
    int dv_cnt_be = 0, err_cnt_be = 0, dv_cnt_le = 0, err_cnt_le = 0;
    logic [W-1:0] good_be = '0, good_le = '0;
    exp_t q_be[$];
    exp_t q_le[$];

    uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(0)) dut_be (
        .clk(clk), .i_reset_n(rst_n), .i_rx(rx),
        .o_data(be_data), .o_dv(be_dv), .o_frame_err(be_err), .o_busy(be_busy)
    );

    uart_rx #(.WIDTH(W), .DIVISOR(D), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .i_reset_n(rst_n), .i_rx(rx),
        .o_data(le_data), .o_dv(le_dv), .o_frame_err(le_err), .o_busy(le_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the MSB-first receiver
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] want;
        if (be_dv || be_err) begin
            if (be_dv) begin dv_cnt_be++; dv_cyc_be = cyc; end
            if (be_err) err_cnt_be++;
            checks++;
            if (q_be.size() == 0) begin
                $display("FAIL be_unexpected_strobe dv=%0b err=%0b data=%h", be_dv, be_err, be_data);
            end else begin
                passed++;
                e = q_be.pop_front();
                want = e.is_err ? good_be : e.data;
                checks++;
                if (be_err !== e.is_err || be_dv !== !e.is_err)
                    $display("FAIL be_strobe_kind dv=%0b err=%0b want_err=%0b", be_dv, be_err, e.is_err);
                else passed++;
                checks++;
                if (be_data !== want) $display("FAIL be_data got=%h want=%h", be_data, want);
                else passed++;
                checks++;
                if (be_busy !== 1'b0) $display("FAIL be_busy_at_strobe got=%0b want=0", be_busy);
                else passed++;
                if (!e.is_err) good_be = e.data;
            end
        end
    end

    // Scoreboard for the LSB-first receiver
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] want;
        if (le_dv || le_err) begin
            if (le_dv) dv_cnt_le++;
            if (le_err) err_cnt_le++;
            checks++;
            if (q_le.size() == 0) begin
                $display("FAIL le_unexpected_strobe dv=%0b err=%0b data=%h", le_dv, le_err, le_data);
            end else begin
                passed++;
                e = q_le.pop_front();
                want = e.is_err ? good_le : e.data;
                checks++;
                if (le_err !== e.is_err || le_dv !== !e.is_err)
                    $display("FAIL le_strobe_kind dv=%0b err=%0b want_err=%0b", le_dv, le_err, e.is_err);
                else passed++;
                checks++;
                if (le_data !== want) $display("FAIL le_data got=%h want=%h", le_data, want);
                else passed++;
                checks++;
                if (le_busy !== 1'b0) $display("FAIL le_busy_at_strobe got=%0b want=0", le_busy);
                else passed++;
                if (!e.is_err) good_le = e.data;
            end
        end
    end

    // Drive one frame; the serial bit order is chosen here, both receivers' views are queued
    task automatic send_frame(input logic [W-1:0] val, input bit lsb_first, input logic stop_val);
        logic [W-1:0] be_v, le_v;
        logic         b;
        exp_t         e;
        be_v = '0;
        le_v = '0;
        for (int i = 0; i < W; i++) begin
            b = lsb_first ? val[i] : val[W-1-i];
            be_v = {be_v[W-2:0], b};
            le_v = {b, le_v[W-1:1]};
        end
        e.is_err = !stop_val;
        e.data = be_v;
        q_be.push_back(e);
        e.data = le_v;
        q_le.push_back(e);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (D) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx = lsb_first ? val[i] : val[W-1-i];
            repeat (D) @(negedge clk);
        end
        rx = stop_val;
        repeat (D - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        idle(5);
        checks++;
        if ({be_data, be_dv, be_err, be_busy} !== {{W{1'b0}}, 3'b000})
            $display("FAIL reset_be data=%h dv=%0b err=%0b busy=%0b want all 0", be_data, be_dv, be_err, be_busy);
        else passed++;
        checks++;
        if ({le_data, le_dv, le_err, le_busy} !== {{W{1'b0}}, 3'b000})
            $display("FAIL reset_le data=%h dv=%0b err=%0b busy=%0b want all 0", le_data, le_dv, le_err, le_busy);
        else passed++;
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_basic;
        int lat;
        int d0;
        d0 = dv_cnt_be;
        dv_cyc_be = -1;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        lat = dv_cyc_be - start_cyc + 1;
        checks++;
        if (lat !== 2 + 1 + D/2 + (W + 1) * D + 1)
            $display("FAIL basic_latency got=%0d want=%0d", lat, 2 + 1 + D/2 + (W + 1) * D + 1);
        else passed++;
        checks++;
        if (be_data !== 8'hA5 || dv_cnt_be - d0 !== 1)
            $display("FAIL basic_a5 data=%h pulses=%0d want data=a5 pulses=1", be_data, dv_cnt_be - d0);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int d0, e0;
        d0 = dv_cnt_be;
        e0 = err_cnt_be;
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(20);
        checks++;
        if (dv_cnt_be - d0 !== 2 || err_cnt_be - e0 !== 0 || be_data !== 8'hC3)
            $display("FAIL b2b dv=%0d err=%0d data=%h want dv=2 err=0 data=c3",
                     dv_cnt_be - d0, err_cnt_be - e0, be_data);
        else passed++;
        checks++;
        if (q_be.size() + q_le.size() !== 0)
            $display("FAIL b2b_drain pending=%0d want 0", q_be.size() + q_le.size());
        else passed++;
    endtask

    task automatic test_glitch;
        int busy_cnt, d0, e0;
        busy_cnt = 0;
        d0 = dv_cnt_be + dv_cnt_le;
        e0 = err_cnt_be + err_cnt_le;
        @(negedge clk);
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        for (int i = 0; i < 4 * D; i++) begin
            @(negedge clk);
            if (be_busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt < 1 || busy_cnt > 53)
            $display("FAIL glitch_busy cycles=%0d want 1..53", busy_cnt);
        else passed++;
        checks++;
        if (be_busy !== 1'b0 || dv_cnt_be + dv_cnt_le - d0 !== 0 || err_cnt_be + err_cnt_le - e0 !== 0)
            $display("FAIL glitch_idle busy=%0b strobes=%0d want busy=0 strobes=0",
                     be_busy, dv_cnt_be + dv_cnt_le - d0 + err_cnt_be + err_cnt_le - e0);
        else passed++;
    endtask

    task automatic test_frame_err;
        logic [W-1:0] prior;
        int d0, e0;
        prior = be_data;
        d0 = dv_cnt_be;
        e0 = err_cnt_be;
        send_frame(8'h5A, 1'b0, 1'b0);
        idle(3000);
        checks++;
        if (err_cnt_be - e0 !== 1 || dv_cnt_be - d0 !== 0 || be_data !== prior)
            $display("FAIL frame_err errs=%0d dvs=%0d data=%h want errs=1 dvs=0 data=%h",
                     err_cnt_be - e0, dv_cnt_be - d0, be_data, prior);
        else passed++;
        checks++;
        if (be_busy !== 1'b0) $display("FAIL held_low_busy got=%0b want=0", be_busy);
        else passed++;
        rx = 1'b1;
        idle(2 * D);
        checks++;
        if (err_cnt_be - e0 !== 1 || be_busy !== 1'b0)
            $display("FAIL after_release errs=%0d busy=%0b want errs=1 busy=0", err_cnt_be - e0, be_busy);
        else passed++;
    endtask

    task automatic test_endian;
        send_frame(8'h01, 1'b1, 1'b1);
        idle(20);
        checks++;
        if (le_data !== 8'h01) $display("FAIL endian_le got=%h want=01", le_data);
        else passed++;
        checks++;
        if (be_data !== 8'h80) $display("FAIL endian_be got=%h want=80", be_data);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int d0;
        @(negedge clk);
        rx = 1'b0;
        idle(D);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            idle(D);
        end
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (be_busy !== 1'b0 || be_data !== 8'h00 || le_data !== 8'h00)
            $display("FAIL reset_mid busy=%0b be=%h le=%h want 0", be_busy, be_data, le_data);
        else passed++;
        good_be = '0;
        good_le = '0;
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(50);
        d0 = dv_cnt_be;
        send_frame(8'h77, 1'b0, 1'b1);
        idle(20);
        checks++;
        if (be_data !== 8'h77 || dv_cnt_be - d0 !== 1)
            $display("FAIL reset_mid_77 data=%h pulses=%0d want data=77 pulses=1", be_data, dv_cnt_be - d0);
        else passed++;
        checks++;
        if (q_be.size() + q_le.size() !== 0)
            $display("FAIL final_drain pending=%0d want 0", q_be.size() + q_le.size());
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_endian();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
